// File: rtl/alu_pkg.sv
// Shared ALU checker types and the reference ALU function.
// Operands are handled at ALU_MAX_W bits; callers truncate to their own width.
package alu_pkg;

  localparam int ALU_MAX_W = 32;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_XNOR = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_ADD  = 3'd6,
    OP_SUB  = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    CHK_IDLE = 2'd0,
    CHK_RUN  = 2'd1,
    CHK_HALT = 2'd2
  } chk_state_e;

  // Add/sub results are correct modulo 2^n for any n <= ALU_MAX_W once truncated.
  function automatic logic [ALU_MAX_W-1:0] alu_ref(input alu_op_e op,
                                                   input logic [ALU_MAX_W-1:0] a,
                                                   input logic [ALU_MAX_W-1:0] b);
    logic [ALU_MAX_W-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_result_checker_if.sv
// Transaction bus into the ALU result checker: valid/ready plus op, operands and observed result.
// The master drives a transaction; the slave raises in_ready when it can take it.
interface alu_result_checker_if #(
  parameter int WIDTH = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;

  modport master (
    output in_valid, op, a, b, result,
    input  in_ready
  );

  modport slave (
    input  in_valid, op, a, b, result,
    output in_ready
  );

endinterface

// File: rtl/alu_ref_model.sv
// Combinational expected-value generator for the ALU; zero latency, no handshake.
// WIDTH must not exceed alu_pkg::ALU_MAX_W.
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] exp_val
);

  logic [ALU_MAX_W-1:0] a_ext;
  logic [ALU_MAX_W-1:0] b_ext;

  always_comb begin
    a_ext            = '0;
    b_ext            = '0;
    a_ext[WIDTH-1:0] = a;
    b_ext[WIDTH-1:0] = b;
    exp_val          = WIDTH'(alu_ref(alu_op_e'(op), a_ext, b_ext));
  end

endmodule

// File: rtl/alu_result_checker.sv
// Two-stage ALU result checker: accept + expected value, then compare into saturating counts.
// Results land one edge after acceptance; in_ready drops combinationally behind a halting mismatch.
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CW           = 16,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  alu_result_checker_if.slave  bus,
  output logic [CW-1:0]        pass_count,
  output logic [CW-1:0]        fail_count,
  output logic                 fail_seen,
  output logic                 halted,
  output logic [2:0]           fail_op,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b,
  output logic [WIDTH-1:0]     fail_got,
  output logic [WIDTH-1:0]     fail_exp
);

  localparam logic [1:0]    IDLE    = CHK_IDLE;
  localparam logic [1:0]    RUN     = CHK_RUN;
  localparam logic [1:0]    HALT    = CHK_HALT;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [1:0]       state;
  logic [1:0]       state_nxt;

  logic             s1_vld;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_got;
  logic [WIDTH-1:0] s1_exp;

  logic [WIDTH-1:0] ref_exp;
  logic             s1_mis;
  logic             halt_req;
  logic             accept;
  logic             clr;

  alu_ref_model #(.WIDTH(WIDTH)) u_ref (
    .op      (bus.op),
    .a       (bus.a),
    .b       (bus.b),
    .exp_val (ref_exp)
  );

  assign s1_mis       = s1_vld && (s1_got != s1_exp);
  assign halt_req     = s1_mis && STOP_ON_FAIL;
  assign bus.in_ready = (state == RUN) && !halt_req;
  assign accept       = bus.in_valid && bus.in_ready;
  // stop beats start; a suppressed start leaves counters untouched
  assign clr          = start && !stop;
  assign halted       = (state == HALT);

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = IDLE;
    end else if (start) begin
      state_nxt = RUN;
    end else if ((state == RUN) && halt_req) begin
      state_nxt = HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stage 1: an entry not refilled by accept is dropped after its compare edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_op  <= '0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_got <= '0;
      s1_exp <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_op  <= bus.op;
        s1_a   <= bus.a;
        s1_b   <= bus.b;
        s1_got <= bus.result;
        s1_exp <= ref_exp;
      end
    end
  end

  // Stage 2: score the stage-1 entry; start discards it along with the counts.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pass_count <= '0;
      fail_count <= '0;
      fail_seen  <= 1'b0;
      fail_op    <= '0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_got   <= '0;
      fail_exp   <= '0;
    end else if (s1_vld) begin
      if (s1_mis) begin
        if (fail_count != CNT_MAX) begin
          fail_count <= fail_count + 1'b1;
        end
        if (!fail_seen) begin
          fail_seen <= 1'b1;
          fail_op   <= s1_op;
          fail_a    <= s1_a;
          fail_b    <= s1_b;
          fail_got  <= s1_got;
          fail_exp  <= s1_exp;
        end
      end else if (pass_count != CNT_MAX) begin
        pass_count <= pass_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: a halting instance (CW=16) and a free-running one (CW=2)
// share control; a scoreboard queue per instance feeds an independent reference model.
module tb_alu_result_checker;

  localparam int IDLE = 0;
  localparam int RUN  = 1;
  localparam int HALT = 2;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] got;
    logic [3:0] exp;
  } txn_t;

  typedef struct packed {
    logic [15:0] pass;
    logic [15:0] fail;
    logic        seen;
    logic        halt;
    logic        rdy;
    logic [2:0]  fop;
    logic [3:0]  fa;
    logic [3:0]  fb;
    logic [3:0]  fg;
    logic [3:0]  fe;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic       vld [2];
  logic [2:0] opv [2];
  logic [3:0] av  [2];
  logic [3:0] bv  [2];
  logic [3:0] rv  [2];

  alu_result_checker_if #(.WIDTH(4)) bus_h ();
  alu_result_checker_if #(.WIDTH(4)) bus_c ();

  assign bus_h.in_valid = vld[0];
  assign bus_h.op       = opv[0];
  assign bus_h.a        = av[0];
  assign bus_h.b        = bv[0];
  assign bus_h.result   = rv[0];
  assign bus_c.in_valid = vld[1];
  assign bus_c.op       = opv[1];
  assign bus_c.a        = av[1];
  assign bus_c.b        = bv[1];
  assign bus_c.result   = rv[1];

  logic [15:0] pass_h, fail_h;
  logic [1:0]  pass_c, fail_c;
  logic        seen_h, seen_c, halt_h, halt_c;
  logic [2:0]  fop_h, fop_c;
  logic [3:0]  fa_h, fb_h, fg_h, fe_h, fa_c, fb_c, fg_c, fe_c;

  alu_result_checker #(.WIDTH(4), .CW(16), .STOP_ON_FAIL(1'b1)) u_dut_h (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .bus(bus_h),
    .pass_count(pass_h), .fail_count(fail_h), .fail_seen(seen_h), .halted(halt_h),
    .fail_op(fop_h), .fail_a(fa_h), .fail_b(fb_h), .fail_got(fg_h), .fail_exp(fe_h)
  );

  alu_result_checker #(.WIDTH(4), .CW(2), .STOP_ON_FAIL(1'b0)) u_dut_c (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .bus(bus_c),
    .pass_count(pass_c), .fail_count(fail_c), .fail_seen(seen_c), .halted(halt_c),
    .fail_op(fop_c), .fail_a(fa_c), .fail_b(fb_c), .fail_got(fg_c), .fail_exp(fe_c)
  );

  obs_t obs0, obs1;
  always_comb begin
    obs0 = '0;
    obs0.pass = pass_h;  obs0.fail = fail_h; obs0.seen = seen_h; obs0.halt = halt_h;
    obs0.rdy  = bus_h.in_ready;
    obs0.fop  = fop_h;   obs0.fa = fa_h; obs0.fb = fb_h; obs0.fg = fg_h; obs0.fe = fe_h;
    obs1 = '0;
    obs1.pass = {14'b0, pass_c}; obs1.fail = {14'b0, fail_c}; obs1.seen = seen_c;
    obs1.halt = halt_c;  obs1.rdy = bus_c.in_ready;
    obs1.fop  = fop_c;   obs1.fa = fa_c; obs1.fb = fb_c; obs1.fg = fg_c; obs1.fe = fe_c;
  end

  int   n_checks = 0;
  int   n_errors = 0;
  obs_t mdl [2];
  int   m_state [2];
  txn_t q0 [$];
  txn_t q1 [$];
  logic rst_s, start_s, stop_s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic obs_t get_obs(input int d);
    return (d == 0) ? obs0 : obs1;
  endfunction

  function automatic logic [3:0] tb_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a ^ b);
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return a + b;
      default: return a - b;
    endcase
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic bit head_mis(input int d);
    if (qsize(d) == 0) return 1'b0;
    if (d == 0) return q0[0].got != q0[0].exp;
    return q1[0].got != q1[0].exp;
  endfunction

  function automatic bit m_ready(input int d);
    return (m_state[d] == RUN) && !((d == 0) && head_mis(d));
  endfunction

  task automatic flush(input int d);
    if (d == 0) q0.delete(); else q1.delete();
  endtask

  task automatic model_edge(input int d, input bit acc, input txn_t nt);
    txn_t        t;
    bit          halt_now;
    logic [15:0] sat;
    sat = (d == 0) ? 16'hFFFF : 16'h0003;
    if (rst_s) begin
      mdl[d] = '0;
      m_state[d] = IDLE;
      flush(d);
      return;
    end
    halt_now = (m_state[d] == RUN) && (d == 0) && head_mis(d);
    if (start_s && !stop_s) begin
      flush(d);
      mdl[d] = '0;
    end else if (qsize(d) > 0) begin
      t = (d == 0) ? q0.pop_front() : q1.pop_front();
      if (t.got == t.exp) begin
        if (mdl[d].pass != sat) mdl[d].pass = mdl[d].pass + 16'd1;
      end else begin
        if (mdl[d].fail != sat) mdl[d].fail = mdl[d].fail + 16'd1;
        if (!mdl[d].seen) begin
          mdl[d].seen = 1'b1;
          mdl[d].fop = t.op; mdl[d].fa = t.a; mdl[d].fb = t.b;
          mdl[d].fg = t.got; mdl[d].fe = t.exp;
        end
      end
    end
    if (acc) begin
      if (d == 0) q0.push_back(nt); else q1.push_back(nt);
    end
    if (stop_s) m_state[d] = IDLE;
    else if (start_s) m_state[d] = RUN;
    else if (halt_now) m_state[d] = HALT;
  endtask

  // One clock: in_ready compared to the model, then both models advanced.
  task automatic tick();
    bit   acc [2];
    txn_t nt  [2];
    obs_t o;
    for (int d = 0; d < 2; d++) begin
      o = get_obs(d);
      check($sformatf("%s.in_ready", (d == 0) ? "h" : "c"), 32'(o.rdy), 32'(m_ready(d)));
      acc[d] = vld[d] && m_ready(d);
      nt[d]  = '{op: opv[d], a: av[d], b: bv[d], got: rv[d], exp: tb_ref(opv[d], av[d], bv[d])};
    end
    rst_s = rst; start_s = start; stop_s = stop;
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d, acc[d], nt[d]);
    @(negedge clk);
  endtask

  task automatic send(input int d, input logic [2:0] op, input logic [3:0] a,
                      input logic [3:0] b, input logic [3:0] res);
    vld[d] = 1'b1; opv[d] = op; av[d] = a; bv[d] = b; rv[d] = res;
    tick();
    vld[d] = 1'b0;
  endtask

  task automatic pulse(input bit do_start, input bit do_stop);
    start = do_start; stop = do_stop;
    tick();
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic check_all(input int d, input string tag);
    obs_t o;
    o = get_obs(d);
    check({tag, ".pass"},   32'(o.pass), 32'(mdl[d].pass));
    check({tag, ".fail"},   32'(o.fail), 32'(mdl[d].fail));
    check({tag, ".seen"},   32'(o.seen), 32'(mdl[d].seen));
    check({tag, ".halted"}, 32'(o.halt), 32'(m_state[d] == HALT));
    check({tag, ".fop"},    32'(o.fop),  32'(mdl[d].fop));
    check({tag, ".fa"},     32'(o.fa),   32'(mdl[d].fa));
    check({tag, ".fb"},     32'(o.fb),   32'(mdl[d].fb));
    check({tag, ".fgot"},   32'(o.fg),   32'(mdl[d].fg));
    check({tag, ".fexp"},   32'(o.fe),   32'(mdl[d].fe));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0; opv[d] = '0; av[d] = '0; bv[d] = '0; rv[d] = '0;
      mdl[d] = '0; m_state[d] = IDLE;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all(0, "reset_h");
    check_all(1, "reset_c");
    check("reset_rdy_h", 32'(bus_h.in_ready), 32'd0);

    // XNOR sweep, both matching
    pulse(1'b1, 1'b0);
    send(0, 3'd3, 4'b1100, 4'b1001, 4'b1010);
    send(0, 3'd3, 4'b0000, 4'b0011, 4'b1100);
    tick();
    check("xnor_pass", 32'(pass_h), 32'd2);
    check("xnor_fail", 32'(fail_h), 32'd0);
    check("xnor_seen", 32'(seen_h), 32'd0);
    check_all(0, "xnor");

    // ADD mismatch halts; back-to-back valid must be refused
    send(0, 3'd6, 4'hF, 4'h1, 4'h1);
    check("halt_rdy_same_cycle", 32'(bus_h.in_ready), 32'd0);
    vld[0] = 1'b1; opv[0] = 3'd0; av[0] = 4'hF; bv[0] = 4'hF; rv[0] = 4'hF;
    tick();
    vld[0] = 1'b0;
    tick();
    check("halt_halted", 32'(halt_h), 32'd1);
    check("halt_fail",   32'(fail_h), 32'd1);
    check("halt_pass",   32'(pass_h), 32'd2);
    check("halt_got",    32'(fg_h),   32'h1);
    check("halt_exp",    32'(fe_h),   32'h0);
    check_all(0, "halt");

    // Free-running instance: three mismatches then two matches
    pulse(1'b1, 1'b0);
    send(1, 3'd0, 4'hF, 4'h3, 4'h0);
    send(1, 3'd1, 4'h1, 4'h2, 4'h0);
    send(1, 3'd2, 4'h5, 4'h5, 4'h1);
    send(1, 3'd4, 4'hF, 4'hF, 4'h0);
    send(1, 3'd5, 4'h0, 4'h0, 4'hF);
    tick();
    check("cont_fail", 32'(fail_c), 32'd3);
    check("cont_pass", 32'(pass_c), 32'd2);
    check("cont_fop",  32'(fop_c),  32'd0);
    check("cont_fexp", 32'(fe_c),   32'h3);
    check("cont_halt", 32'(halt_c), 32'd0);
    check_all(1, "cont");

    // SUB wrap on the halting instance (cleared by the last start)
    send(0, 3'd7, 4'h2, 4'h5, 4'hD);
    tick();
    check("sub_pass", 32'(pass_h), 32'd1);
    check("sub_fail", 32'(fail_h), 32'd0);

    // Saturation at CW=2
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send(1, 3'd6, 4'(i), 4'h1, 4'(i + 1));
    tick();
    check("sat_pass", 32'(pass_c), 32'd3);
    check_all(1, "sat");

    // start and stop together: stop wins
    pulse(1'b1, 1'b1);
    check("startstop_rdy",  32'(bus_h.in_ready), 32'd0);
    check("startstop_halt", 32'(halt_h), 32'd0);
    tick();

    // stop with a stage-1 entry still counts it
    pulse(1'b1, 1'b0);
    send(0, 3'd2, 4'h6, 4'h3, 4'h5);
    pulse(1'b0, 1'b1);
    check("stop_pass", 32'(pass_h), 32'd1);
    check("stop_rdy",  32'(bus_h.in_ready), 32'd0);
    check_all(0, "stop");

    // reset in the middle of a stream
    pulse(1'b1, 1'b0);
    vld[1] = 1'b1; opv[1] = 3'd0; av[1] = 4'hF; bv[1] = 4'hF; rv[1] = 4'hF;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_pass_c", 32'(pass_c), 32'd0);
    check("rst_rdy_c",  32'(bus_c.in_ready), 32'd0);
    check_all(0, "rst_h");
    check_all(1, "rst_c");
    tick();
    tick();
    vld[1] = 1'b0;
    pulse(1'b1, 1'b0);
    check("restart_rdy", 32'(bus_h.in_ready), 32'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
